// File: rtl/sdet_share_ctrl.sv
// Time-shared "10010" Moore detector serving two word requesters.
// Round-robin grant, per-requester saved detector context, MSB-first serialization.
module sdet_share_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  input  logic             ctx_clr,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CW-1:0]    match_cnt
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_A = 3'd0,
    S_B = 3'd1,
    S_C = 3'd2,
    S_D = 3'd3,
    S_E = 3'd4,
    S_F = 3'd5
  } det_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctl_t;

  ctl_t             state, state_nxt;
  det_t             det, det_nxt;
  det_t             ctx0, ctx1;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt, cnt_inc;
  logic [BW-1:0]    bcnt;
  logic             id, last;
  logic             res_id;
  logic [CW-1:0]    res_cnt;
  logic             g0, g1;
  logic             last_bit;

  function automatic det_t det_step(input det_t s, input logic j);
    det_t n;
    n = S_A;
    case (s)
      S_A:     n = j ? S_B : S_A;
      S_B:     n = j ? S_B : S_C;
      S_C:     n = j ? S_B : S_D;
      S_D:     n = j ? S_E : S_A;
      S_E:     n = j ? S_B : S_F;
      S_F:     n = j ? S_B : S_D;
      default: n = S_A;
    endcase
    return n;
  endfunction

  // Grants are masked while reset is held so busy drops immediately on abort.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state == IDLE && rst && !ctx_clr) begin
      if (req0 && (!req1 || last))
        g0 = 1'b1;
      else if (req1)
        g1 = 1'b1;
    end
  end

  always_comb begin
    det_nxt  = det_step(det, sreg[WIDTH-1]);
    cnt_inc  = cnt + CW'(det_nxt == S_F);
    last_bit = (bcnt == BW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (g0 || g1) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Result registers load on the last shift edge so they are valid during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det     <= S_A;
      ctx0    <= S_A;
      ctx1    <= S_A;
      sreg    <= '0;
      cnt     <= '0;
      bcnt    <= '0;
      id      <= 1'b0;
      last    <= 1'b1;
      res_id  <= 1'b0;
      res_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctx_clr) begin
            ctx0 <= S_A;
            ctx1 <= S_A;
          end else if (g0 || g1) begin
            sreg <= g1 ? din1 : din0;
            det  <= g1 ? ctx1 : ctx0;
            cnt  <= '0;
            bcnt <= '0;
            id   <= g1;
            last <= g1;
          end
        end
        SHIFT: begin
          det  <= det_nxt;
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          bcnt <= bcnt + BW'(1);
          cnt  <= cnt_inc;
          if (last_bit) begin
            res_cnt <= cnt_inc;
            res_id  <= id;
          end
        end
        DONE: begin
          if (id)
            ctx1 <= det;
          else
            ctx0 <= det;
        end
        default: ;
      endcase
    end
  end

  assign gnt0      = g0;
  assign gnt1      = g1;
  assign busy      = (state != IDLE) || g0 || g1;
  assign done      = (state == DONE);
  assign done_id   = res_id;
  assign match_cnt = res_cnt;

endmodule
